// File: rtl/soc_sysid_pkg.sv
// Shared register map, CAPS field layout and CONTROL bit indices for soc_sysid_v2.
package soc_sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_CAPS      = 3'd2;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
  localparam logic [2:0] ADDR_PRESCALE  = 3'd6;
  localparam logic [2:0] ADDR_CONTROL   = 3'd7;

  localparam int unsigned CAPS_MAJOR_LSB  = 24;
  localparam int unsigned CAPS_MINOR_LSB  = 16;
  localparam int unsigned CAPS_UPTIME_BIT = 0;

  localparam int unsigned CTRL_CLEAR  = 0;
  localparam int unsigned CTRL_FREEZE = 1;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_sysid_uptime.sv
// Prescaler, 64-bit uptime counter and HI shadow; only built with SOC_SYSID_UPTIME_EN.
module soc_sysid_uptime (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        freeze_i,
  input  logic [31:0] prescale_i,
  input  logic        prescale_wr_i,
  input  logic        snap_i,
  output logic [31:0] count_lo_o,
  output logic [31:0] shadow_hi_o
);

  logic [31:0] pre_q, pre_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    // Shadow takes the pre-edge upper word so LO/HI always form one 64-bit value.
    if (snap_i) hi_d = cnt_q[63:32];
    if (clear_i) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (prescale_wr_i) begin
      pre_d = '0;
    end else if (!freeze_i) begin
      if (pre_q == prescale_i) begin
        pre_d = '0;
        cnt_d = cnt_q + 64'd1;
      end else begin
        pre_d = pre_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      hi_q  <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  assign count_lo_o  = cnt_q[31:0];
  assign shadow_hi_o = hi_q;

endmodule

// File: rtl/soc_sysid_v2.sv
// System-ID Avalon-MM slave; uptime/prescaler/CONTROL present when SOC_SYSID_UPTIME_EN is defined.
module soc_sysid_v2
  import soc_sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_ID        = 32'h0000_0000,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'd1668877045,
  parameter logic [7:0]  VER_MAJOR       = 8'd2,
  parameter logic [7:0]  VER_MINOR       = 8'd0,
  parameter logic [31:0] SCRATCH_RST     = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata
);

`ifdef SOC_SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  logic        wr_en;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] caps;

  assign wr_en = write & ~read;

  always_comb begin
    caps = '0;
    caps[CAPS_MAJOR_LSB +: 8]  = VER_MAJOR;
    caps[CAPS_MINOR_LSB +: 8]  = VER_MINOR;
    caps[CAPS_UPTIME_BIT]      = UPTIME_PRESENT;
  end

  always_comb begin
    scratch_d = scratch_q;
    if (wr_en && address == ADDR_SCRATCH) scratch_d = be_merge(scratch_q, writedata, byteenable);
  end

`ifdef SOC_SYSID_UPTIME_EN
  logic [31:0] prescale_q, prescale_d;
  logic        freeze_q, freeze_d;
  logic        clear, prescale_wr, snap;
  logic [31:0] count_lo, shadow_hi;

  assign clear       = wr_en && address == ADDR_CONTROL && writedata[CTRL_CLEAR];
  assign prescale_wr = wr_en && address == ADDR_PRESCALE;
  assign snap        = read && address == ADDR_UPTIME_LO;

  always_comb begin
    prescale_d = prescale_q;
    freeze_d   = freeze_q;
    if (prescale_wr) prescale_d = be_merge(prescale_q, writedata, byteenable);
    if (wr_en && address == ADDR_CONTROL) freeze_d = writedata[CTRL_FREEZE];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
      freeze_q   <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      freeze_q   <= freeze_d;
    end
  end

  soc_sysid_uptime u_uptime (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear_i       (clear),
    .freeze_i      (freeze_q),
    .prescale_i    (prescale_q),
    .prescale_wr_i (prescale_wr),
    .snap_i        (snap),
    .count_lo_o    (count_lo),
    .shadow_hi_o   (shadow_hi)
  );
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (read) begin
      case (address)
        ADDR_ID:        rdata_d = SYSID_ID;
        ADDR_TIMESTAMP: rdata_d = SYSID_TIMESTAMP;
        ADDR_CAPS:      rdata_d = caps;
        ADDR_SCRATCH:   rdata_d = scratch_q;
`ifdef SOC_SYSID_UPTIME_EN
        ADDR_UPTIME_LO: rdata_d = count_lo;
        ADDR_UPTIME_HI: rdata_d = shadow_hi;
        ADDR_PRESCALE:  rdata_d = prescale_q;
        ADDR_CONTROL: begin
          rdata_d = '0;
          rdata_d[CTRL_FREEZE] = freeze_q;
        end
`endif
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= SCRATCH_RST;
      rdata_q   <= '0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
    end
  end

  assign readdata = rdata_q;

endmodule
